// File: rtl/cell_comm_fa_packetizer_pkg.sv
// Shared constants, header layout helper and state encodings for the FA packetizer.
package cell_comm_fa_packetizer_pkg;

    localparam logic [7:0] HDR_MAGIC     = 8'hA5;
    localparam int         WORDS_PER_BPM = 4;
    localparam int         HDR_MAGIC_LSB = 24;
    localparam int         HDR_CLIP_LSB  = 16;
    localparam int         HDR_STALE_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SEND    = 2'd2
    } pkt_state_e;

    typedef enum logic [1:0] {
        WORD_HDR = 2'd0,
        WORD_X   = 2'd1,
        WORD_Y   = 2'd2,
        WORD_S   = 2'd3
    } pkt_word_e;

    localparam pkt_word_e LAST_WORD = pkt_word_e'(2'(WORDS_PER_BPM - 1));

    // Assembles a per-BPM header word; idx arrives already zero-extended to 15 bits.
    function automatic logic [31:0] make_header(input logic [7:0]  clip,
                                                input logic        stale,
                                                input logic [14:0] idx);
        logic [31:0] hdr;
        hdr                         = '0;
        hdr[HDR_MAGIC_LSB +: 8]     = HDR_MAGIC;
        hdr[HDR_CLIP_LSB +: 8]      = clip;
        hdr[HDR_STALE_BIT]          = stale;
        hdr[14:0]                   = idx;
        return hdr;
    endfunction

endpackage

// File: rtl/cell_comm_fa_capture.sv
// Per-BPM capture slot: toggle edge detect, sample/clip capture and fresh flag.
module cell_comm_fa_capture
    import cell_comm_fa_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADC_COUNT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  toggle_in,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic [DATA_WIDTH-1:0] s_in,
    input  logic [ADC_COUNT-1:0]  clip_in,
    input  logic                  clear_in,
    output logic                  toggle_edge,
    output logic                  fresh,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic [DATA_WIDTH-1:0] s_out,
    output logic [ADC_COUNT-1:0]  clip_out,
    output logic                  overrun
);

    logic                  toggle_q, toggle_d;
    logic                  fresh_q, fresh_d;
    logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, s_q, s_d;
    logic [ADC_COUNT-1:0]  clip_q, clip_d;

    // Edge detect and capture; a new edge wins over the packet-start clear so it lands in the next packet.
    always_comb begin
        toggle_edge = toggle_in ^ toggle_q;
        toggle_d    = toggle_in;
        fresh_d     = fresh_q;
        x_d         = x_q;
        y_d         = y_q;
        s_d         = s_q;
        clip_d      = clip_q;
        overrun     = 1'b0;
        if (toggle_edge) begin
            x_d     = x_in;
            y_d     = y_in;
            s_d     = s_in;
            clip_d  = clip_in;
            fresh_d = 1'b1;
            overrun = fresh_q && !clear_in;
        end else if (clear_in) begin
            fresh_d = 1'b0;
        end
    end

    // Capture state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
            fresh_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            s_q      <= '0;
            clip_q   <= '0;
        end else begin
            toggle_q <= toggle_d;
            fresh_q  <= fresh_d;
            x_q      <= x_d;
            y_q      <= y_d;
            s_q      <= s_d;
            clip_q   <= clip_d;
        end
    end

    assign fresh    = fresh_q;
    assign x_out    = x_q;
    assign y_out    = y_q;
    assign s_out    = s_q;
    assign clip_out = clip_q;

endmodule

// File: rtl/cell_comm_fa_packetizer.sv
// FA packetizer top: collects per-BPM samples and emits one AXIS packet per FA cycle.
module cell_comm_fa_packetizer
    import cell_comm_fa_packetizer_pkg::*;
#(
    parameter int NUM_BPMS       = 2,
    parameter int ADC_COUNT      = 4,
    parameter int FOFB_IDX_WIDTH = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                           sysClk,
    input  logic                           sysReset_n,
    input  logic [NUM_BPMS-1:0]            sysBpmEnable,
    input  logic [FOFB_IDX_WIDTH-1:0]      sysFofbIdxBase,
    input  logic [NUM_BPMS*DATA_WIDTH-1:0] sysFA_X,
    input  logic [NUM_BPMS*DATA_WIDTH-1:0] sysFA_Y,
    input  logic [NUM_BPMS*DATA_WIDTH-1:0] sysFA_S,
    input  logic [NUM_BPMS-1:0]            sysFaToggle,
    input  logic [NUM_BPMS*ADC_COUNT-1:0]  sysClippedAdc,
    output logic                           txTvalid,
    output logic [31:0]                    txTdata,
    output logic                           txTlast,
    input  logic                           txTready,
    output logic [31:0]                    packetCount,
    output logic [31:0]                    overrunCount,
    output logic [31:0]                    timeoutCount
);

    localparam int BPM_IDX_W = (NUM_BPMS > 1) ? $clog2(NUM_BPMS) : 1;
    localparam int TIMER_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_BPMS-1:0]   edge_vec, fresh_vec, overrun_vec;
    logic [DATA_WIDTH-1:0] cap_x [NUM_BPMS];
    logic [DATA_WIDTH-1:0] cap_y [NUM_BPMS];
    logic [DATA_WIDTH-1:0] cap_s [NUM_BPMS];
    logic [ADC_COUNT-1:0]  cap_clip [NUM_BPMS];
    logic                  load_send, timeout_hit, pkt_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BPMS; gi++) begin : g_bpm
            cell_comm_fa_capture #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADC_COUNT  (ADC_COUNT)
            ) u_capture (
                .clk         (sysClk),
                .rst_n       (sysReset_n),
                .toggle_in   (sysFaToggle[gi]),
                .x_in        (sysFA_X[gi*DATA_WIDTH +: DATA_WIDTH]),
                .y_in        (sysFA_Y[gi*DATA_WIDTH +: DATA_WIDTH]),
                .s_in        (sysFA_S[gi*DATA_WIDTH +: DATA_WIDTH]),
                .clip_in     (sysClippedAdc[gi*ADC_COUNT +: ADC_COUNT]),
                .clear_in    (load_send),
                .toggle_edge (edge_vec[gi]),
                .fresh       (fresh_vec[gi]),
                .x_out       (cap_x[gi]),
                .y_out       (cap_y[gi]),
                .s_out       (cap_s[gi]),
                .clip_out    (cap_clip[gi]),
                .overrun     (overrun_vec[gi])
            );
        end
    endgenerate

    pkt_state_e                state_q, state_d;
    pkt_word_e                 word_q, word_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [BPM_IDX_W-1:0]      bpm_q, bpm_d;
    logic [DATA_WIDTH-1:0]     send_x_q [NUM_BPMS];
    logic [DATA_WIDTH-1:0]     send_x_d [NUM_BPMS];
    logic [DATA_WIDTH-1:0]     send_y_q [NUM_BPMS];
    logic [DATA_WIDTH-1:0]     send_y_d [NUM_BPMS];
    logic [DATA_WIDTH-1:0]     send_s_q [NUM_BPMS];
    logic [DATA_WIDTH-1:0]     send_s_d [NUM_BPMS];
    logic [ADC_COUNT-1:0]      send_clip_q [NUM_BPMS];
    logic [ADC_COUNT-1:0]      send_clip_d [NUM_BPMS];
    logic [NUM_BPMS-1:0]       send_fresh_q, send_fresh_d, send_en_q, send_en_d;
    logic [FOFB_IDX_WIDTH-1:0] send_base_q, send_base_d;
    logic [31:0]               packet_count_q, packet_count_d;
    logic [31:0]               overrun_count_q, overrun_count_d;
    logic [31:0]               timeout_count_q, timeout_count_d;
    logic [BPM_IDX_W-1:0]      first_en, next_bpm;
    logic                      has_next, all_fresh;

    // Lowest enabled BPM, where a freshly loaded packet starts.
    always_comb begin
        first_en = '0;
        for (int j = NUM_BPMS - 1; j >= 0; j--) begin
            if (sysBpmEnable[j]) first_en = BPM_IDX_W'(j);
        end
    end

    // Next enabled BPM above the current one; none left means this BPM closes the packet.
    always_comb begin
        next_bpm = bpm_q;
        has_next = 1'b0;
        for (int j = NUM_BPMS - 1; j >= 0; j--) begin
            if (send_en_q[j] && (j > int'(bpm_q))) begin
                next_bpm = BPM_IDX_W'(j);
                has_next = 1'b1;
            end
        end
    end

    assign all_fresh = ((fresh_vec & sysBpmEnable) == sysBpmEnable);

    // Packet FSM: wait for first enabled edge, collect until complete or timed out, then stream.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bpm_d       = bpm_q;
        word_d      = word_q;
        load_send   = 1'b0;
        timeout_hit = 1'b0;
        pkt_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((edge_vec & sysBpmEnable) != '0) begin
                    state_d = ST_COLLECT;
                    timer_d = '0;
                end
            end
            ST_COLLECT: begin
                if (sysBpmEnable == '0) begin
                    state_d = ST_IDLE;
                end else if (all_fresh) begin
                    load_send = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    load_send   = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (load_send) begin
                    state_d = ST_SEND;
                    bpm_d   = first_en;
                    word_d  = WORD_HDR;
                end
            end
            ST_SEND: begin
                if (txTready) begin
                    if (word_q == LAST_WORD) begin
                        if (has_next) begin
                            bpm_d  = next_bpm;
                            word_d = WORD_HDR;
                        end else begin
                            pkt_done = 1'b1;
                            timer_d  = '0;
                            state_d  = ((fresh_vec | edge_vec) != '0) ? ST_COLLECT : ST_IDLE;
                        end
                    end else begin
                        case (word_q)
                            WORD_HDR: word_d = WORD_X;
                            WORD_X:   word_d = WORD_Y;
                            default:  word_d = WORD_S;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Send buffer: snapshot of captures, fresh, enable and base taken at packet start.
    always_comb begin
        send_x_d     = send_x_q;
        send_y_d     = send_y_q;
        send_s_d     = send_s_q;
        send_clip_d  = send_clip_q;
        send_fresh_d = send_fresh_q;
        send_en_d    = send_en_q;
        send_base_d  = send_base_q;
        if (load_send) begin
            send_x_d     = cap_x;
            send_y_d     = cap_y;
            send_s_d     = cap_s;
            send_clip_d  = cap_clip;
            send_fresh_d = fresh_vec;
            send_en_d    = sysBpmEnable;
            send_base_d  = sysFofbIdxBase;
        end
    end

    // Wrapping status counters; several BPMs may overrun in the same cycle.
    always_comb begin
        overrun_count_d = overrun_count_q;
        for (int j = 0; j < NUM_BPMS; j++) begin
            overrun_count_d = overrun_count_d + {31'b0, overrun_vec[j]};
        end
        packet_count_d  = packet_count_q + {31'b0, pkt_done};
        timeout_count_d = timeout_count_q + {31'b0, timeout_hit};
    end

    // State, pointer, send buffer and counter registers.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q         <= ST_IDLE;
            word_q          <= WORD_HDR;
            timer_q         <= '0;
            bpm_q           <= '0;
            for (int j = 0; j < NUM_BPMS; j++) begin
                send_x_q[j]    <= '0;
                send_y_q[j]    <= '0;
                send_s_q[j]    <= '0;
                send_clip_q[j] <= '0;
            end
            send_fresh_q    <= '0;
            send_en_q       <= '0;
            send_base_q     <= '0;
            packet_count_q  <= '0;
            overrun_count_q <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            timer_q         <= timer_d;
            bpm_q           <= bpm_d;
            send_x_q        <= send_x_d;
            send_y_q        <= send_y_d;
            send_s_q        <= send_s_d;
            send_clip_q     <= send_clip_d;
            send_fresh_q    <= send_fresh_d;
            send_en_q       <= send_en_d;
            send_base_q     <= send_base_d;
            packet_count_q  <= packet_count_d;
            overrun_count_q <= overrun_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    logic [FOFB_IDX_WIDTH-1:0] idx_w;
    logic [14:0]               hdr_idx;
    logic [7:0]                clip8;

    // Output word mux; everything reads zero outside SEND, so reset clears the bus at once.
    always_comb begin
        idx_w                          = send_base_q + FOFB_IDX_WIDTH'(bpm_q);
        hdr_idx                        = '0;
        hdr_idx[FOFB_IDX_WIDTH-1:0]    = idx_w;
        clip8                          = '0;
        clip8[ADC_COUNT-1:0]           = send_clip_q[bpm_q];
        txTvalid = (state_q == ST_SEND);
        txTdata  = '0;
        txTlast  = 1'b0;
        if (state_q == ST_SEND) begin
            case (word_q)
                WORD_HDR: txTdata = make_header(clip8, !send_fresh_q[bpm_q], hdr_idx);
                WORD_X:   txTdata = send_x_q[bpm_q];
                WORD_Y:   txTdata = send_y_q[bpm_q];
                default: begin
                    txTdata = send_s_q[bpm_q];
                    txTlast = !has_next;
                end
            endcase
        end
    end

    assign packetCount  = packet_count_q;
    assign overrunCount = overrun_count_q;
    assign timeoutCount = timeout_count_q;

endmodule

// File: tb/tb_cell_comm_fa_packetizer.sv
// Self-checking bench for the FA packetizer: directed scenarios plus randomized rounds
// compared against a packet-level model of what each FA cycle should produce.
module tb_cell_comm_fa_packetizer;

    localparam int NB = 2;
    localparam int AC = 4;
    localparam int IW = 9;
    localparam int TO = 16;

    logic              sysClk = 1'b0;
    logic              sysReset_n;
    logic [NB-1:0]     sysBpmEnable;
    logic [IW-1:0]     sysFofbIdxBase;
    logic [NB*32-1:0]  sysFA_X, sysFA_Y, sysFA_S;
    logic [NB-1:0]     sysFaToggle;
    logic [NB*AC-1:0]  sysClippedAdc;
    logic              txTvalid, txTlast, txTready;
    logic [31:0]       txTdata, packetCount, overrunCount, timeoutCount;

    cell_comm_fa_packetizer #(
        .NUM_BPMS       (NB),
        .ADC_COUNT      (AC),
        .FOFB_IDX_WIDTH (IW),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sysClk         (sysClk),
        .sysReset_n     (sysReset_n),
        .sysBpmEnable   (sysBpmEnable),
        .sysFofbIdxBase (sysFofbIdxBase),
        .sysFA_X        (sysFA_X),
        .sysFA_Y        (sysFA_Y),
        .sysFA_S        (sysFA_S),
        .sysFaToggle    (sysFaToggle),
        .sysClippedAdc  (sysClippedAdc),
        .txTvalid       (txTvalid),
        .txTdata        (txTdata),
        .txTlast        (txTlast),
        .txTready       (txTready),
        .packetCount    (packetCount),
        .overrunCount   (overrunCount),
        .timeoutCount   (timeoutCount)
    );

    // Free-running system clock.
    always #5 sysClk = ~sysClk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: last captured sample per BPM, fresh since last packet, toggle levels.
    logic [31:0]   mX [NB];
    logic [31:0]   mY [NB];
    logic [31:0]   mS [NB];
    logic [AC-1:0] mClip [NB];
    bit            mFresh [NB];
    logic [NB-1:0] tglLvl;
    int            expPackets, expOverruns, expTimeouts;
    logic [32:0]   expQ [$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NB; i++) begin
            mX[i] = '0; mY[i] = '0; mS[i] = '0; mClip[i] = '0; mFresh[i] = 0;
        end
        tglLvl      = '0;
        expPackets  = 0;
        expOverruns = 0;
        expTimeouts = 0;
        expQ.delete();
    endtask

    // Present new samples on the BPMs in mask and flip their toggles in this cycle.
    task automatic applyStimulus(input logic [NB-1:0] mask, input bit directed);
        logic [31:0]   x, y, s;
        logic [AC-1:0] c;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) begin
                if (directed) begin
                    x = 32'(i * 3 + 1); y = 32'(i * 3 + 2); s = 32'(i * 3 + 3); c = '0;
                end else begin
                    x = $urandom; y = $urandom; s = $urandom; c = AC'($urandom);
                end
                sysFA_X[i*32 +: 32]       = x;
                sysFA_Y[i*32 +: 32]       = y;
                sysFA_S[i*32 +: 32]       = s;
                sysClippedAdc[i*AC +: AC] = c;
                if (mFresh[i]) expOverruns++;
                mFresh[i] = 1;
                mX[i] = x; mY[i] = y; mS[i] = s; mClip[i] = c;
                tglLvl[i] = ~tglLvl[i];
            end
        end
        sysFaToggle = tglLvl;
    endtask

    // Expected beats of the packet that the current enable/base and fresh set will produce.
    task automatic buildPacket();
        int          hi;
        bit          tmo;
        logic [31:0] hdr;
        hi  = -1;
        tmo = 0;
        for (int i = 0; i < NB; i++) begin
            if (sysBpmEnable[i]) begin
                hi = i;
                if (!mFresh[i]) tmo = 1;
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (sysBpmEnable[i]) begin
                hdr = 32'hA500_0000 | (32'(mClip[i]) << 16) | (mFresh[i] ? 32'h0 : 32'h8000)
                      | ((32'(sysFofbIdxBase) + 32'(i)) % 32'd512);
                expQ.push_back({1'b0, hdr});
                expQ.push_back({1'b0, mX[i]});
                expQ.push_back({1'b0, mY[i]});
                expQ.push_back({(i == hi) ? 1'b1 : 1'b0, mS[i]});
            end
        end
        if (tmo) expTimeouts++;
        expPackets++;
        for (int i = 0; i < NB; i++) mFresh[i] = 0;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, ".packetCount"}, packetCount, 32'(expPackets));
        checkOutput({tag, ".overrunCount"}, overrunCount, 32'(expOverruns));
        checkOutput({tag, ".timeoutCount"}, timeoutCount, 32'(expTimeouts));
    endtask

    // Drain beats at negedge, compare to expQ and check stall stability. maxBeats=0 means whole packet.
    task automatic collectPacket(input int maxBeats, input bit randReady,
                                 input bit scramble, input bit midToggle);
        int          beats;
        int          cycles;
        bit          done;
        bit          prevStall;
        bit          toggled;
        logic [31:0] prevData;
        logic        prevLast;
        logic [32:0] e;
        beats = 0; cycles = 0; done = 0; prevStall = 0; toggled = 0;
        prevData = '0; prevLast = 1'b0;
        while (!done && cycles < 300) begin
            if (prevStall) begin
                checkOutput("stallValid", {31'b0, txTvalid}, 32'd1);
                checkOutput("stallData", txTdata, prevData);
                checkOutput("stallLast", {31'b0, txTlast}, {31'b0, prevLast});
            end
            prevStall = 0;
            txTready  = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (txTvalid) begin
                if (txTready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("extraBeat", 32'(beats + 1), 32'(beats));
                        done = 1;
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("beatData", txTdata, e[31:0]);
                        checkOutput("beatLast", {31'b0, txTlast}, {31'b0, e[32]});
                    end
                    beats++;
                    if (txTlast || (maxBeats != 0 && beats == maxBeats)) done = 1;
                    if (scramble && beats == 1) begin
                        sysBpmEnable   = NB'($urandom_range(1, 3));
                        sysFofbIdxBase = IW'($urandom);
                    end
                    if (midToggle && !toggled && beats == 2) begin
                        applyStimulus(2'b11, 0);
                        toggled = 1;
                    end
                end else begin
                    prevStall = 1;
                    prevData  = txTdata;
                    prevLast  = txTlast;
                end
            end
            @(posedge sysClk);
            @(negedge sysClk);
            cycles++;
        end
        checkOutput("packetDone", {31'b0, done}, 32'd1);
        if (maxBeats == 0) checkOutput("beatsLeft", 32'(expQ.size()), 32'd0);
        expQ.delete();
        txTready = 1'b0;
    endtask

    initial begin
        logic [NB-1:0] en, mask;

        sysReset_n     = 1'b0;
        sysBpmEnable   = '0;
        sysFofbIdxBase = '0;
        sysFA_X        = '0;
        sysFA_Y        = '0;
        sysFA_S        = '0;
        sysFaToggle    = '0;
        sysClippedAdc  = '0;
        txTready       = 1'b0;
        modelReset();

        repeat (2) @(negedge sysClk);
        checkOutput("rst.valid", {31'b0, txTvalid}, 32'd0);
        checkOutput("rst.data", txTdata, 32'd0);
        checkOutput("rst.last", {31'b0, txTlast}, 32'd0);
        checkCounters("rst");
        sysReset_n = 1'b1;
        @(negedge sysClk);

        $display("[TB] timeout with only BPM0 toggling");
        sysBpmEnable = 2'b11; sysFofbIdxBase = 9'd10;
        applyStimulus(2'b01, 0);
        buildPacket();
        collectPacket(0, 0, 0, 0);
        checkCounters("timeout");

        $display("[TB] both BPMs, fixed samples");
        applyStimulus(2'b11, 1);
        buildPacket();
        collectPacket(0, 0, 0, 0);
        checkCounters("basic");

        $display("[TB] BPM0 disabled");
        sysBpmEnable = 2'b10;
        applyStimulus(2'b11, 1);
        buildPacket();
        collectPacket(0, 0, 0, 0);
        checkCounters("onlyBpm1");

        $display("[TB] overrun on BPM0");
        sysBpmEnable = 2'b11;
        applyStimulus(2'b01, 0);
        repeat (2) @(negedge sysClk);
        applyStimulus(2'b01, 0);
        repeat (2) @(negedge sysClk);
        applyStimulus(2'b10, 0);
        buildPacket();
        collectPacket(0, 0, 0, 0);
        checkCounters("overrun");

        $display("[TB] randomized rounds with backpressure");
        for (int r = 0; r < 12; r++) begin
            en             = NB'($urandom_range(1, 3));
            sysBpmEnable   = en;
            sysFofbIdxBase = IW'($urandom);
            mask           = NB'($urandom_range(1, 3));
            while ((mask & en) == '0) mask = NB'($urandom_range(1, 3));
            applyStimulus(mask, 0);
            buildPacket();
            collectPacket(0, 1, 1, 0);
            checkCounters("random");
        end

        $display("[TB] new samples captured while sending");
        sysBpmEnable = 2'b11;
        applyStimulus(2'b11, 0);
        buildPacket();
        collectPacket(0, 1, 0, 1);
        buildPacket();
        collectPacket(0, 1, 0, 0);
        checkCounters("doubleBuffer");

        $display("[TB] reset in the middle of a packet");
        applyStimulus(2'b11, 0);
        buildPacket();
        collectPacket(3, 0, 0, 0);
        sysReset_n  = 1'b0;
        sysFaToggle = '0;
        #1;
        checkOutput("midRst.valid", {31'b0, txTvalid}, 32'd0);
        checkOutput("midRst.data", txTdata, 32'd0);
        checkOutput("midRst.last", {31'b0, txTlast}, 32'd0);
        modelReset();
        checkCounters("midRst");
        @(negedge sysClk);
        sysReset_n = 1'b1;
        @(negedge sysClk);
        applyStimulus(2'b11, 0);
        buildPacket();
        collectPacket(0, 0, 0, 0);
        checkCounters("afterRst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
